simon_128192: RTL and testbench

- Iterative SIMON 128/192 block-cipher core: 128-bit block, 192-bit key, 69 rounds, one round per clock.
- Expands the key into an internal round-key store, then encrypts or decrypts one block per request.
- Uses request/acknowledge handshakes on both the key and data sides, so a host controller can stream blocks through it.

---
 rtl/simon_128192.sv | 191 +++++++++++++++++++
 tb/tb_simon_128192.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/simon_128192.sv
// SIMON 128/192 iterative core: expands the key into a round-key store, then
// processes one block per request at one round per clock.
module simon_128192 #(
    parameter int N  = 64,
    parameter int M  = 3,
    parameter int T  = 69,
    parameter int Co = 7
) (
    input  logic                clk,
    input  logic                nR,
    input  logic                newData,
    input  logic                newKey,
    input  logic                enc_dec,
    input  logic                readData,
    input  logic [1:0][N-1:0]   BLOCK,
    input  logic [M-1:0][N-1:0] KEY,
    output logic                loadData,
    output logic                loadKey,
    output logic                doneData,
    output logic                doneKey,
    output logic [1:0][N-1:0]   outData,
    output logic [3:0]          mode
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        KEYEXP = 4'd1,
        READY  = 4'd2,
        RUN    = 4'd3,
        DONE   = 4'd4
    } state_t;

    localparam logic [N-1:0] C  = {{(N-2){1'b1}}, 2'b00};
    // Leftmost character of the z3 string is sequence bit 0, i.e. Z3[61].
    localparam logic [61:0]  Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

    function automatic logic [N-1:0] rol(input logic [N-1:0] x, input int unsigned s);
        return (x << s) | (x >> (N - s));
    endfunction

    function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int unsigned s);
        return (x >> s) | (x << (N - s));
    endfunction

    function automatic logic [N-1:0] rf(input logic [N-1:0] x);
        return (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
    endfunction

    state_t            r_state, w_next;
    logic [N-1:0]      r_keys [T];
    logic [N-1:0]      r_k0, r_k1, r_k2;
    logic [N-1:0]      r_x, r_y;
    logic [1:0][N-1:0] r_out;
    logic [Co-1:0]     r_cnt;
    logic [5:0]        r_zi;
    logic              r_enc;
    logic              r_loadData, r_loadKey, r_doneData, r_doneKey;

    logic              w_key_latch, w_key_last, w_data_latch, w_finish, w_read;
    logic [Co-1:0]     w_kidx;
    logic [N-1:0]      w_knew, w_rk;

    // Sliding window k[i], k[i+1], k[i+2] produces k[i+3] without store reads.
    assign w_knew = C ^ {{(N-1){1'b0}}, Z3[6'd61 - r_zi]} ^ r_k0 ^ ror(r_k2, 3) ^ ror(r_k2, 4);
    assign w_kidx = r_enc ? r_cnt : Co'(T - 1) - r_cnt;
    assign w_rk   = r_keys[w_kidx];

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_key_latch  = 1'b0;
        w_key_last   = 1'b0;
        w_data_latch = 1'b0;
        w_finish     = 1'b0;
        w_read       = 1'b0;
        case (r_state)
            IDLE: begin
                if (newKey) begin
                    w_key_latch = 1'b1;
                    w_next      = KEYEXP;
                end
            end
            KEYEXP: begin
                if (r_cnt == Co'(T - 1)) begin
                    w_key_last = 1'b1;
                    w_next     = READY;
                end
            end
            READY: begin
                if (newKey) begin
                    w_key_latch = 1'b1;
                    w_next      = KEYEXP;
                end else if (newData && r_doneKey) begin
                    w_data_latch = 1'b1;
                    w_next       = RUN;
                end
            end
            RUN: begin
                if (r_cnt == Co'(T)) begin
                    w_finish = 1'b1;
                    w_next   = DONE;
                end
            end
            DONE: begin
                if (readData) begin
                    w_read = 1'b1;
                    w_next = READY;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_key_latch) begin
            r_keys[0] <= KEY[0];
            r_keys[1] <= KEY[1];
            r_keys[2] <= KEY[2];
        end else if (r_state == KEYEXP) begin
            r_keys[r_cnt] <= w_knew;
        end
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            r_k0       <= '0;
            r_k1       <= '0;
            r_k2       <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_out      <= '0;
            r_cnt      <= '0;
            r_zi       <= '0;
            r_enc      <= 1'b0;
            r_loadData <= 1'b0;
            r_loadKey  <= 1'b0;
            r_doneData <= 1'b0;
            r_doneKey  <= 1'b0;
        end else begin
            r_loadKey  <= w_key_latch;
            r_loadData <= w_data_latch;
            if (w_key_latch) begin
                r_doneKey <= 1'b0;
                r_k0      <= KEY[0];
                r_k1      <= KEY[1];
                r_k2      <= KEY[2];
                r_cnt     <= Co'(3);
                r_zi      <= '0;
            end else if (r_state == KEYEXP) begin
                r_k0  <= r_k1;
                r_k1  <= r_k2;
                r_k2  <= w_knew;
                r_zi  <= (r_zi == 6'd61) ? '0 : r_zi + 6'd1;
                r_cnt <= r_cnt + Co'(1);
                if (w_key_last) r_doneKey <= 1'b1;
            end
            if (w_data_latch) begin
                r_x   <= BLOCK[1];
                r_y   <= BLOCK[0];
                r_enc <= enc_dec;
                r_cnt <= '0;
            end else if (r_state == RUN && !w_finish) begin
                if (r_enc) begin
                    r_x <= r_y ^ rf(r_x) ^ w_rk;
                    r_y <= r_x;
                end else begin
                    r_y <= r_x ^ rf(r_y) ^ w_rk;
                    r_x <= r_y;
                end
                r_cnt <= r_cnt + Co'(1);
            end
            if (w_finish) begin
                r_out      <= {r_x, r_y};
                r_doneData <= 1'b1;
            end
            if (w_read) r_doneData <= 1'b0;
        end
    end

    assign loadData = r_loadData;
    assign loadKey  = r_loadKey;
    assign doneData = r_doneData;
    assign doneKey  = r_doneKey;
    assign outData  = r_out;
    assign mode     = r_state;

endmodule

// File: tb/tb_simon_128192.sv
// Directed bench for simon_128192: key load, streamed encrypt/decrypt with
// handshakes, and asynchronous reset behaviour.
module tb_simon_128192;

    logic         clk = 1'b0;
    logic         nR, newData, newKey, enc_dec, readData;
    logic [127:0] BLOCK;
    logic [191:0] KEY;
    logic         loadData, loadKey, doneData, doneKey;
    logic [127:0] outData;
    logic [3:0]   mode;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [191:0] K = 192'h1716151413121110_0F0E0D0C0B0A0908_0706050403020100;

    logic [127:0] pt [5];
    logic [127:0] ct [5];

    simon_128192 #(.N(64), .M(3), .T(69), .Co(7)) dut (
        .clk      (clk),
        .nR       (nR),
        .newData  (newData),
        .newKey   (newKey),
        .enc_dec  (enc_dec),
        .readData (readData),
        .BLOCK    (BLOCK),
        .KEY      (KEY),
        .loadData (loadData),
        .loadKey  (loadKey),
        .doneData (doneData),
        .doneKey  (doneKey),
        .outData  (outData),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] bf(input logic [63:0] x);
        return ({x[62:0], x[63]} & {x[55:0], x[63:56]}) ^ {x[61:0], x[63:62]};
    endfunction

    // Reference cipher used to derive ciphertexts for the streamed blocks.
    function automatic logic [127:0] simon_ref(input logic [127:0] blk, input logic [191:0] key,
                                               input logic enc);
        logic [63:0] k [69];
        logic [63:0] x, y, t;
        logic [61:0] z;
        z = 62'b11011011101011000110010111100000010010001010011100110100001111;
        k[0] = key[63:0];
        k[1] = key[127:64];
        k[2] = key[191:128];
        for (int i = 0; i < 66; i++) begin
            t = {k[i+2][2:0], k[i+2][63:3]};
            t = t ^ {t[0], t[63:1]};
            k[i+3] = 64'hFFFF_FFFF_FFFF_FFFC ^ 64'(z[61 - (i % 62)]) ^ k[i] ^ t;
        end
        x = blk[127:64];
        y = blk[63:0];
        if (enc) begin
            for (int i = 0; i < 69; i++) begin
                t = x;
                x = y ^ bf(x) ^ k[i];
                y = t;
            end
        end else begin
            for (int i = 68; i >= 0; i--) begin
                t = y;
                y = x ^ bf(y) ^ k[i];
                x = t;
            end
        end
        return {x, y};
    endfunction

    task automatic load_key(input logic [127:0] blk, input logic enc);
        int cyc;
        logic early, extra;
        KEY     = K;
        BLOCK   = blk;
        enc_dec = enc;
        newKey  = 1'b1;
        newData = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (loadKey) break;
        end
        chk("loadKey", 128'(loadKey), 128'd1);
        chk("mode_kexp", 128'(mode), 128'd1);
        newKey = 1'b0;
        cyc    = 0;
        early  = 1'b0;
        extra  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cyc++;
            if (loadData) early = 1'b1;
            if (loadKey) extra = 1'b1;
            if (doneKey) break;
        end
        chk("doneKey", 128'(doneKey), 128'd1);
        chk("keylat_66_67", 128'(cyc >= 66 && cyc <= 67), 128'd1);
        chk("load_before_key", 128'(early), 128'd0);
        chk("loadKey_pulse", 128'(extra), 128'd0);
        chk("mode_ready", 128'(mode), 128'd2);
    endtask

    // newData is already high with block 0 on entry.
    task automatic stream(input logic enc);
        int lat;
        logic [127:0] exp_v;
        for (int b = 0; b < 5; b++) begin
            exp_v = enc ? ct[b] : pt[b];
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (loadData) break;
            end
            chk($sformatf("load%0d", b), 128'(loadData), 128'd1);
            newData = 1'b0;
            enc_dec = ~enc;
            lat = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                lat++;
                if (doneData) break;
            end
            chk($sformatf("lat%0d", b), 128'(lat), 128'd70);
            chk($sformatf("out%0d", b), outData, exp_v);
            for (int d = 1; d <= 3; d++) begin
                @(negedge clk);
                chk($sformatf("hold%0d_%0d", b, d), outData, exp_v);
                chk($sformatf("hold_flags%0d_%0d", b, d), 128'({doneData, loadData}), 128'b10);
                if (d == 1 && b < 4) begin
                    BLOCK   = enc ? pt[b+1] : ct[b+1];
                    enc_dec = enc;
                    newData = 1'b1;
                end
                if (d == 3) readData = 1'b1;
            end
            @(negedge clk);
            readData = 1'b0;
            chk($sformatf("read_flags%0d", b), 128'({doneData, loadData}), 128'b00);
            chk($sformatf("keep%0d", b), outData, exp_v);
        end
    endtask

    initial begin
        logic seen;
        pt[0] = 128'h206572656874206E6568772065626972;
        pt[1] = 128'hA8D5F7DE0123FEDC01234567FEDCBA98;
        pt[2] = 128'h5BC92D014567BA9889ABCDEF01234567;
        pt[3] = 128'hF2B48D4589AB765401234567FEDCBA98;
        pt[4] = 128'h567F11DECDEF321089ABCDEF01234567;
        ct[0] = 128'hC4AC61EFFCDC0D4F6C9C8D6E2597B85B;
        for (int i = 1; i < 5; i++) ct[i] = simon_ref(pt[i], K, 1'b1);

        nR = 1'b0; newData = 1'b0; newKey = 1'b0; enc_dec = 1'b0; readData = 1'b0;
        BLOCK = '0; KEY = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_flags", 128'({loadData, loadKey, doneData, doneKey}), 128'd0);
        chk("rst_out", outData, 128'd0);
        chk("rst_mode", 128'(mode), 128'd0);
        nR = 1'b1;
        @(negedge clk);

        load_key(pt[0], 1'b1);
        stream(1'b1);

        nR = 1'b0;
        @(negedge clk);
        chk("rst2_flags", 128'({loadData, loadKey, doneData, doneKey}), 128'd0);
        chk("rst2_out", outData, 128'd0);
        nR = 1'b1;
        @(negedge clk);
        load_key(ct[0], 1'b0);
        stream(1'b0);

        BLOCK   = pt[0];
        enc_dec = 1'b1;
        newData = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (loadData) break;
        end
        chk("load_run", 128'(loadData), 128'd1);
        repeat (10) @(negedge clk);
        chk("mode_run", 128'(mode), 128'd3);
        nR = 1'b0;
        #1;
        chk("arst_flags", 128'({loadData, loadKey, doneData, doneKey}), 128'd0);
        chk("arst_out", outData, 128'd0);
        chk("arst_mode", 128'(mode), 128'd0);
        @(negedge clk);
        nR   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (loadData) seen = 1'b1;
        end
        chk("no_load_after_rst", 128'(seen), 128'd0);
        chk("idle_after_rst", 128'({mode, doneKey}), 128'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
